// File: rtl/bitrev_reorder_pkg.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_pkg
// Shared constants for the bit-reversal reorder buffer.
//   BANK_W     : width of the ping-pong bank select (two banks -> one bit)
//   NUM_BANKS  : number of frame banks in the reorder memory
//   FIFO_DEPTH : entries in the output skid FIFO behind the registered RAM
// ---------------------------------------------------------------------------
package bitrev_reorder_pkg;

    localparam int BANK_W     = 1;
    localparam int NUM_BANKS  = 2;
    localparam int FIFO_DEPTH = 2;

endpackage : bitrev_reorder_pkg

// File: rtl/bitrev.sv
// ---------------------------------------------------------------------------
// bitrev
// Combinational bit reversal of an index: out_o[i] = in_i[WIDTH-1-i].
//   in_i  : index in natural order
//   out_o : bit-reversed index
// ---------------------------------------------------------------------------
module bitrev #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign out_o[i] = in_i[WIDTH-1-i];
    end

endmodule : bitrev

// File: rtl/bitrev_reorder_ram.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_ram
// Simple dual-port memory holding two frames (NUM_BANKS * 2^LOG2_N words).
// One write port, one read port with a registered output (1-cycle latency),
// written so that it maps onto a block RAM.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address {bank, offset}
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates only on a read
//   raddr_i : read address {bank, offset}
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module bitrev_reorder_ram
    import bitrev_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_N     = 10
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [BANK_W+LOG2_N-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       re_i,
    input  logic [BANK_W+LOG2_N-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = NUM_BANKS << LOG2_N;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule : bitrev_reorder_ram

// File: rtl/bitrev_reorder.sv
// ---------------------------------------------------------------------------
// bitrev_reorder
// Streaming bit-reversal reorder buffer for FFT frames of N = 2^LOG2_N
// samples. Ping-pong banks: one frame is written while the previous one is
// read, sustaining one sample per clock. Reordering happens on the write
// side (scattered write address), so reads are always sequential and the
// read counter directly gives the natural-order bin index.
//   clk       : clock
//   reset     : synchronous, active-high reset
//   rev_en    : 1 = bit-reverse the frame, 0 = natural order (sampled at
//               the first sample of each frame)
//   in_data   : input sample          in_valid / in_ready  : input handshake
//   out_data  : reordered sample      out_valid / out_ready: output handshake
//   out_index : natural-order bin index of out_data
//   out_last  : high on bin N-1
// ---------------------------------------------------------------------------
module bitrev_reorder
    import bitrev_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_N     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rev_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LOG2_N-1:0]     out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int                N        = 1 << LOG2_N;
    localparam int                ADDR_W   = BANK_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

    // Write side state
    logic [LOG2_N-1:0]    wcnt_q, wcnt_d;
    logic [BANK_W-1:0]    wbank_q, wbank_d;
    logic [NUM_BANKS-1:0] rev_flag_q, rev_flag_d;

    // Read side state
    logic [LOG2_N-1:0]    rcnt_q, rcnt_d;
    logic [BANK_W-1:0]    rbank_q, rbank_d;
    logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
    logic                 pend_q, pend_d;
    logic [LOG2_N-1:0]    pend_idx_q;

    // Output FIFO (two entries, absorbs the RAM read latency under stalls)
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [LOG2_N-1:0]     fifo_idx_q  [FIFO_DEPTH];
    logic [0:0]            wr_ptr_q, wr_ptr_d;
    logic [0:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  in_fire;
    logic                  wr_rev;
    logic [LOG2_N-1:0]     wcnt_rev;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  pop;
    logic [2:0]            slots_used;
    logic                  rd_issue;

    // ---------------- write side ----------------
    assign in_ready = !bank_full_q[wbank_q];
    assign in_fire  = in_valid && in_ready;

    // The first sample of a frame uses rev_en directly; later samples use
    // the value latched with that first sample.
    assign wr_rev = (wcnt_q == '0) ? rev_en : rev_flag_q[wbank_q];

    bitrev #(
        .WIDTH (LOG2_N)
    ) u_bitrev (
        .in_i  (wcnt_q),
        .out_o (wcnt_rev)
    );

    assign ram_waddr = {wbank_q, (wr_rev ? wcnt_rev : wcnt_q)};

    // ---------------- read side ----------------
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;

    // Entries the FIFO will hold next cycle before this cycle's read lands;
    // issuing only below two guarantees the FIFO never overflows.
    assign slots_used = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_issue   = bank_full_q[rbank_q] && (slots_used < 3'd2);
    assign ram_raddr  = {rbank_q, rcnt_q};

    bitrev_reorder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_ram (
        .clk     (clk),
        .we_i    (in_fire),
        .waddr_i (ram_waddr),
        .wdata_i (in_data),
        .re_i    (rd_issue),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        rev_flag_d  = rev_flag_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        bank_full_d = bank_full_q;
        pend_d      = rd_issue;
        wr_ptr_d    = pend_q ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
        occ_d       = occ_q + {1'b0, pend_q} - {1'b0, pop};

        // A clear can only hit a full bank and a set only an empty one, so
        // when both happen in one cycle they address different banks.
        if (rd_issue) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == LAST_IDX) begin
                bank_full_d[rbank_q] = 1'b0;
                rbank_d              = ~rbank_q;
            end
        end

        if (in_fire) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) begin
                rev_flag_d[wbank_q] = rev_en;
            end
            if (wcnt_q == LAST_IDX) begin
                bank_full_d[wbank_q] = 1'b1;
                wbank_d              = ~wbank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q      <= '0;
            wbank_q     <= '0;
            rev_flag_q  <= '0;
            rcnt_q      <= '0;
            rbank_q     <= '0;
            bank_full_q <= '0;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= 2'd0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            rev_flag_q  <= rev_flag_d;
            rcnt_q      <= rcnt_d;
            rbank_q     <= rbank_d;
            bank_full_q <= bank_full_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Data path registers carry no reset; occupancy qualifies them.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            pend_idx_q <= rcnt_q;
        end
        if (pend_q) begin
            fifo_data_q[wr_ptr_q] <= ram_rdata;
            fifo_idx_q[wr_ptr_q]  <= pend_idx_q;
        end
    end

    // Outputs read zero whenever the FIFO is empty (including after reset).
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_index = out_valid ? fifo_idx_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && (fifo_idx_q[rd_ptr_q] == LAST_IDX);

endmodule : bitrev_reorder

// File: tb/tb_bitrev_reorder.sv
module tb_bitrev_reorder;

    localparam int DW  = 16;
    localparam int L2N = 3;
    localparam int N   = 1 << L2N;
    localparam int REV8 [0:7] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic            clk = 1'b0;
    logic            reset;
    logic            rev_en;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic [L2N-1:0]  out_index;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    always #5 clk = ~clk;

    bitrev_reorder #(
        .DATA_WIDTH (DW),
        .LOG2_N     (L2N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rev_en    (rev_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: reverse the bits of an index arithmetically.
    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < L2N; b++) begin
            if ((k >> b) & 1) r += (1 << (L2N - 1 - b));
        end
        return r;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0]  frame_q [$];
    logic [DW-1:0]  exp_q   [$];
    logic [DW-1:0]  obs_q   [$];
    int             obs_cyc [$];
    logic           cur_rev;
    int             out_pos = 0;
    logic           hold_v = 1'b0;
    logic [DW-1:0]  hold_d;
    logic [L2N-1:0] hold_i;

    always @(negedge clk) begin
        if (reset) begin
            frame_q.delete();
            exp_q.delete();
            out_pos = 0;
            hold_v  = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_d);
                chk("stall_index", out_index, hold_i);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_index;

            if (in_valid && in_ready) begin
                if (frame_q.size() == 0) cur_rev = rev_en;
                frame_q.push_back(in_data);
                if (frame_q.size() == N) begin
                    for (int k = 0; k < N; k++)
                        exp_q.push_back(cur_rev ? frame_q[brev(k)] : frame_q[k]);
                    frame_q.delete();
                end
            end

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", exp_q.size(), 1);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_index", out_index, out_pos % N);
                    chk("out_last", out_last, (out_pos % N) == N - 1);
                end
                obs_q.push_back(out_data);
                obs_cyc.push_back(cyc);
                out_pos++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] d, input logic r, output int stalls);
        logic acc;
        acc      = 1'b0;
        stalls   = 0;
        in_data  = d;
        rev_en   = r;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stalls++;
                if (stalls > 1000) begin
                    $display("FAIL send_timeout: in_ready stuck low, observed 0 expected 1");
                    $fatal(1, "input side hung");
                end
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int target, input string tag);
        int g = 0;
        while (out_pos < target && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk(tag, out_pos, target);
    endtask

    initial begin
        int s;
        int stall_tot;
        int acc_cnt;
        int target;
        logic a;

        reset     = 1'b1;
        rev_en    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;

        // Reorder frame 0..7 and output latency
        out_ready = 1'b1;
        obs_q.delete();
        for (int i = 0; i < N; i++) send(DW'(i), 1'b1, s);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge0", out_valid, 0);
        @(negedge clk);
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 1);
        @(posedge clk);
        #1;
        drain(8, "t1_drain");
        chk("t1_count", obs_q.size(), 8);
        for (int k = 0; k < N; k++) chk("t1_order", obs_q[k], REV8[k]);

        // Bypass frame followed by reorder frame
        obs_q.delete();
        for (int i = 0; i < N; i++) send(DW'(i), 1'b0, s);
        for (int i = 0; i < N; i++) send(DW'(8 + i), 1'b1, s);
        idle(1);
        drain(out_pos + 16 - obs_q.size(), "t2_drain");
        for (int k = 0; k < N; k++) chk("t2_bypass", obs_q[k], k);
        for (int k = 0; k < N; k++) chk("t2_reorder", obs_q[N + k], 8 + REV8[k]);

        // Backpressure: two banks fill, then input stalls
        out_ready = 1'b0;
        obs_q.delete();
        target  = out_pos + 16;
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'b1;
            rev_en   = 1'b1;
            in_data  = DW'(100 + acc_cnt);
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) acc_cnt++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc_cnt, 16);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_still_low", in_ready, 0);
        @(negedge clk);
        chk("bp_ready_back", in_ready, 1);
        @(posedge clk);
        #1;
        drain(target, "bp_drain");
        for (int k = 0; k < N; k++) chk("bp_frame0", obs_q[k], 100 + REV8[k]);
        for (int k = 0; k < N; k++) chk("bp_frame1", obs_q[N + k], 108 + REV8[k]);

        // Throughput: four back-to-back frames
        obs_q.delete();
        obs_cyc.delete();
        target    = out_pos + 32;
        stall_tot = 0;
        for (int f = 0; f < 4; f++) begin
            a = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                send(DW'($urandom), a, s);
                stall_tot += s;
            end
        end
        idle(1);
        chk("tp_in_stalls", stall_tot, 0);
        drain(target, "tp_drain");
        chk("tp_continuous", obs_cyc[31] - obs_cyc[0], 31);

        // Random out_ready, random gaps, rev_en wiggled mid-frame
        target = out_pos + 10 * N;
        fork
            begin
                for (int i = 0; i < 10 * N; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(DW'($urandom), 1'($urandom), s);
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(target, "rand_drain");
        idle(3);
        chk("rand_queue_empty", exp_q.size(), 0);

        // rev_en toggles at sample 3: frame keeps the value from sample 0
        obs_q.delete();
        target = out_pos + 8;
        for (int i = 0; i < N; i++) send(DW'(32 + i), (i < 3), s);
        idle(1);
        drain(target, "tog_drain");
        for (int k = 0; k < N; k++) chk("tog_order", obs_q[k], 32 + REV8[k]);

        // Reset during a read and a partial write
        for (int i = 0; i < N; i++) send(DW'(48 + i), 1'b1, s);
        for (int i = 0; i < 5; i++) send(DW'(80 + i), 1'b1, s);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        obs_q.delete();
        for (int i = 0; i < N; i++) send(DW'(64 + i), 1'b1, s);
        idle(1);
        drain(8, "post_rst_drain");
        idle(6);
        chk("post_rst_count", obs_q.size(), 8);
        for (int k = 0; k < N; k++) chk("post_rst_order", obs_q[k], 64 + REV8[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bitrev_reorder
